// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC sequencing and single-outstanding instruction fetch.
// Optional fetch timeout enabled by defining PC_FETCH_TIMEOUT_EN.
module pc_fetch_ctrl #(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned     MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] target_i,
  input  logic             stall_i,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [31:0]      imem_rdata_i,
  output logic             instr_valid_o,
  output logic [31:0]      instr_o,
  output logic [WIDTH-1:0] instr_pc_o,
  output logic [WIDTH-1:0] pc_o,
  output logic             fault_o
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DELIVER,
    FAULT
  } state_t;

  state_t           state;
  logic             kill;
  logic             misaligned;
  logic             timeout;
  logic             to_fault;
  logic [WIDTH-1:0] pc_inc;

  assign misaligned = |target_i[1:0];
  assign pc_inc     = pc_o + WIDTH'(4);

`ifdef PC_FETCH_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;

  assign timeout = (wait_cnt == CW'(MAX_WAIT - 1));

  // Count unacknowledged FETCH cycles; any other state or an ack restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state != FETCH || imem_ack_i) begin
      wait_cnt <= '0;
    end else if (!timeout) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end
`else
  logic unused_max_wait;

  assign timeout         = 1'b0;
  assign unused_max_wait = (MAX_WAIT != 0);
`endif

  assign to_fault =
    ((state == FETCH || state == DELIVER) && redirect_i && misaligned) ||
    (state == FETCH && timeout && !imem_ack_i);

  // Fetch FSM with registered handshake and delivery outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      pc_o          <= RESET_PC;
      imem_req_o    <= 1'b0;
      imem_addr_o   <= RESET_PC;
      instr_valid_o <= 1'b0;
      instr_o       <= '0;
      instr_pc_o    <= '0;
      fault_o       <= 1'b0;
      kill          <= 1'b0;
    end else if (to_fault) begin
      state         <= FAULT;
      fault_o       <= 1'b1;
      imem_req_o    <= 1'b0;
      instr_valid_o <= 1'b0;
      kill          <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state       <= FETCH;
          imem_req_o  <= 1'b1;
          imem_addr_o <= pc_o;
        end
        FETCH: begin
          if (redirect_i) begin
            pc_o <= target_i;
            if (imem_ack_i) begin
              kill        <= 1'b0;
              imem_addr_o <= target_i;
            end else begin
              kill <= 1'b1;
            end
          end else if (imem_ack_i) begin
            if (kill) begin
              kill        <= 1'b0;
              imem_addr_o <= pc_o;
            end else begin
              instr_o       <= imem_rdata_i;
              instr_pc_o    <= pc_o;
              pc_o          <= pc_inc;
              instr_valid_o <= 1'b1;
              imem_req_o    <= 1'b0;
              state         <= DELIVER;
            end
          end
        end
        DELIVER: begin
          if (redirect_i) begin
            pc_o          <= target_i;
            instr_valid_o <= 1'b0;
            imem_req_o    <= 1'b1;
            imem_addr_o   <= target_i;
            state         <= FETCH;
          end else if (!stall_i) begin
            instr_valid_o <= 1'b0;
            imem_req_o    <= 1'b1;
            imem_addr_o   <= pc_o;
            state         <= FETCH;
          end
        end
        FAULT: begin
          state <= FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: randomized fetch traffic checked by a PC-stream
// scoreboard; a second instance covers the RESET_PC wrap case.
module tb_pc_fetch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        redirect, stall, ack;
  logic [31:0] target, rdata;
  logic        req, valid, fault;
  logic [31:0] addr, instr, instr_pc, pc;

  logic        w_req, w_valid, w_fault, w_ack;
  logic [31:0] w_addr, w_instr, w_instr_pc, w_pc, w_rdata;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'h0093, ~a[15:0]};
  endfunction

  assign w_ack   = w_req;
  assign w_rdata = memf(w_addr);

  pc_fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .redirect_i(redirect), .target_i(target), .stall_i(stall),
    .imem_req_o(req), .imem_addr_o(addr),
    .imem_ack_i(ack), .imem_rdata_i(rdata),
    .instr_valid_o(valid), .instr_o(instr), .instr_pc_o(instr_pc),
    .pc_o(pc), .fault_o(fault)
  );

  pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst),
    .redirect_i(1'b0), .target_i(32'h0), .stall_i(1'b0),
    .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_ack_i(w_ack), .imem_rdata_i(w_rdata),
    .instr_valid_o(w_valid), .instr_o(w_instr), .instr_pc_o(w_instr_pc),
    .pc_o(w_pc), .fault_o(w_fault)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  logic [31:0] cur_exp = '0;
  logic [31:0] model_pc = '0;
  logic [31:0] w_exp = 32'hFFFF_FFFC;
  bit          prev_v = 0;
  bit          w_prev = 0;
  int          n_deliv = 0;

  bit          pend = 0;
  int          lat = 0;
  int          lat_lo = 0;
  int          lat_hi = 0;
  logic [31:0] paddr = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops the expected PC whenever a new instruction shows.
  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        prev_v = 0;
        w_prev = 0;
      end else begin
        if (valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_deliver: got pc %h expected none",
                     instr_pc);
          end else begin
            cur_exp = exp_q.pop_front();
            chk("instr_pc", instr_pc, cur_exp);
            chk("instr", instr, memf(cur_exp));
            n_deliv++;
          end
        end else if (valid) begin
          chk("hold_pc", instr_pc, cur_exp);
          chk("hold_instr", instr, memf(cur_exp));
        end
        prev_v = valid;
        if (w_valid && !w_prev) begin
          chk("wrap_pc", w_instr_pc, w_exp);
          chk("wrap_instr", w_instr, memf(w_exp));
          w_exp = w_exp + 32'd4;
        end
        w_prev = w_valid;
      end
    end
  end

  // One cycle of memory response, handshake drive and model update.
  task automatic cycle(input bit rd, input logic [31:0] tgt, input bit st);
    @(negedge clk);
    #1;
    ack = 1'b0;
    if (req) begin
      if (!pend) begin
        pend  = 1;
        lat   = $urandom_range(lat_hi, lat_lo);
        paddr = addr;
      end else begin
        chk("addr_hold", addr, paddr);
      end
      if (lat == 0) begin
        ack   = 1'b1;
        rdata = memf(addr);
        pend  = 0;
      end else begin
        lat--;
      end
    end
    if (valid) chk("no_req_in_deliver", {31'b0, req}, 32'd0);
    redirect = rd && (req || valid);
    target   = tgt;
    stall    = st;
    if (redirect && tgt[1:0] == 2'b00) begin
      model_pc = tgt;
      exp_q.delete();
      exp_q.push_back(tgt);
    end else if (!redirect && valid && !st) begin
      model_pc = model_pc + 32'd4;
      exp_q.push_back(model_pc);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    redirect = 1'b0;
    stall    = 1'b0;
    ack      = 1'b0;
    rdata    = '0;
    target   = '0;
    pend     = 0;
    exp_q.delete();
    #1;
    chk("rst_req", {31'b0, req}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
    repeat (2) @(negedge clk);
    rst      = 1'b1;
    model_pc = 32'd0;
    exp_q.push_back(32'd0);
    w_exp    = 32'hFFFF_FFFC;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int guard;
    logic [31:0] t;
    #2;
    do_reset();

    // Back-to-back fetches with single-cycle ack: one delivery per 2 cycles.
    lat_lo = 0;
    lat_hi = 0;
    d0 = n_deliv;
    repeat (8) cycle(0, '0, 0);
    chk("deliv_count", 32'(n_deliv - d0), 32'd4);

    // Decode stall holds the delivered instruction.
    repeat (6) cycle(0, '0, 1);
    repeat (3) cycle(0, '0, 0);

    // Redirect while a slow fetch is outstanding.
    lat_lo = 3;
    lat_hi = 3;
    guard = 0;
    while (!(req && pend) && guard < 20) begin
      cycle(0, '0, 0);
      guard++;
    end
    chk("pending_fetch_seen", {31'b0, req}, 32'd1);
    cycle(1, 32'h100, 0);
    repeat (14) cycle(0, '0, 0);

    // Redirect during a stalled delivery squashes it.
    lat_lo = 0;
    lat_hi = 0;
    guard = 0;
    while (!valid && guard < 20) begin
      cycle(0, '0, 1);
      guard++;
    end
    chk("stalled_valid", {31'b0, valid}, 32'd1);
    cycle(1, 32'h200, 1);
    @(posedge clk);
    #1;
    chk("squash_valid", {31'b0, valid}, 32'd0);
    repeat (6) cycle(0, '0, 0);

    // Randomized traffic.
    lat_lo = 0;
    lat_hi = 3;
    for (int i = 0; i < 2000; i++) begin
      t = 32'($urandom_range(0, 1023)) << 2;
      cycle($urandom_range(0, 9) == 0, t, $urandom_range(0, 2) == 0);
    end

    // Misaligned redirect target latches the fault.
    lat_lo = 0;
    lat_hi = 0;
    repeat (4) cycle(0, '0, 0);
    cycle(1, 32'h102, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, '0, 0);
      chk("fault_sticky", {31'b0, fault}, 32'd1);
      chk("fault_no_req", {31'b0, req}, 32'd0);
      chk("fault_no_valid", {31'b0, valid}, 32'd0);
    end

    // Reset asserted in the middle of a fetch.
    do_reset();
    lat_lo = 5;
    lat_hi = 5;
    repeat (3) cycle(0, '0, 0);
    @(posedge clk);
    #3;
    do_reset();

    // Fetch that is never acknowledged.
    lat_lo = 1000;
    lat_hi = 1000;
    for (int i = 1; i <= 100; i++) begin
      cycle(0, '0, 0);
`ifdef PC_FETCH_TIMEOUT_EN
      if (i == 15) chk("timeout_not_yet", {31'b0, fault}, 32'd0);
      if (i == 16) chk("timeout_fault", {31'b0, fault}, 32'd1);
`endif
    end
`ifndef PC_FETCH_TIMEOUT_EN
    chk("wait_req", {31'b0, req}, 32'd1);
    chk("wait_no_fault", {31'b0, fault}, 32'd0);
`endif

    do_reset();
    repeat (4) cycle(0, '0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Sequences the program counter and instruction-fetch handshake for the single-issue RV32I core; sits between PC register/next-PC logic and instruction memory.
- Issues one fetch at a time, advances PC by 4 on delivery, applies branch/jump redirects (PCsrc path), and holds the fetched instruction under decode stall.
- Squashes wrong-path fetches; flags misaligned targets.

Parameters:
WIDTH, 32, PC/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
MAX_WAIT, 15, fetch timeout in cycles (used only with optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
redirect_i  in  1  taken branch/jump from execute
target_i  in  WIDTH  redirect target (PC + ImmOp)
stall_i  in  1  decode cannot accept instruction
imem_req_o  out  1  fetch request
imem_addr_o  out  WIDTH  fetch address
imem_ack_i  in  1  fetch data valid
imem_rdata_i  in  32  fetched instruction
instr_valid_o  out  1  instr_o/instr_pc_o valid
instr_o  out  32  delivered instruction
instr_pc_o  out  WIDTH  PC of delivered instruction
pc_o  out  WIDTH  current fetch PC
fault_o  out  1  sticky fault

Behaviour:
- Reset (rst=0, async): state IDLE, pc_o=RESET_PC, imem_req_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, fault_o=0, kill flag=0. Reset mid-fetch abandons the request; late acks are ignored.
- States: IDLE, FETCH, DELIVER, FAULT.
- IDLE: outputs quiet; FETCH next cycle.
- FETCH: imem_req_o=1, imem_addr_o=pc_o, both held stable until imem_ack_i=1. imem_ack_i is sampled only in FETCH. Minimum latency: ack in the first FETCH cycle.
  - Ack, no kill: instr_o<=imem_rdata_i, instr_pc_o<=pc_o, pc_o<=pc_o+4 (mod 2^WIDTH, so 0xFFFF_FFFC wraps to 0), instr_valid_o<=1, go to DELIVER. imem_req_o drops the cycle after ack.
  - Ack with kill set: data discarded, kill cleared, stay in FETCH at the new pc_o. imem_req_o is re-asserted with the new address the next cycle.
- DELIVER: instr_valid_o=1 with outputs stable.
  - stall_i=0: consumed; instr_valid_o<=0, go to FETCH.
  - stall_i=1: hold all outputs unchanged, with no fetch outstanding.
- Redirect (redirect_i=1) in FETCH or DELIVER has highest priority. It acts in the same cycle as ack or consume.
  - target_i[1:0]!=0: go to FAULT.
  - Otherwise pc_o<=target_i.
  - In FETCH with the request not acked this cycle: set kill; request stays asserted at the old address until ack.
  - In FETCH with ack this cycle: data discarded, no kill needed, FETCH at target next cycle.
  - In DELIVER: instr_valid_o<=0 (squash, even if stalled), FETCH at target.
  - Repeated redirects before ack: last target wins, kill remains set.
- Redirect in IDLE is ignored.
- FAULT: fault_o=1, imem_req_o=0, instr_valid_o=0, pc_o frozen. Exit only via reset.
- Throughput: at best one instruction per 2 cycles (FETCH+DELIVER).

Optional Feature:
- Macro: PC_FETCH_TIMEOUT_EN.
- Defined:
  - Counter clears on entering FETCH and increments each FETCH cycle without ack.
  - If MAX_WAIT cycles elapse without ack, go to FAULT (fault_o=1) on the next edge.
  - Counter width is $clog2(MAX_WAIT+1).
- Undefined: no counter; FETCH waits indefinitely.

Test Plan:
- Reset, ack 1 cycle after each req, stall=0 -> imem_addr_o sequence 0,4,8,C; instr_pc_o matches; instr_valid_o pulses every 2 cycles.
- DELIVER with stall_i=1 for 3 cycles, rdata=0x00500093 -> instr_o/instr_valid_o held 3 cycles; no imem_req_o; consumed on stall release.
- Redirect to 0x100 while a FETCH at 0x8 waits 3 cycles for ack -> addr 0x8 held until ack; that data is never delivered; next request addr 0x100; instr_pc_o=0x100.
- Redirect in DELIVER with stall_i=1 -> instr_valid_o=0 next cycle; fetch at target. Redirect to 0x102 -> fault_o=1, req never re-asserted until rst=0.
- RESET_PC=0xFFFF_FFFC -> second fetch addr 0x0. Assert rst low mid-FETCH -> all outputs at reset values immediately.
- With PC_FETCH_TIMEOUT_EN and no ack -> fault_o=1 after 15 FETCH cycles. Without the macro -> still waiting at cycle 100.
